// File: rtl/logic_gate_pkg.sv
// Shared types and helpers for the registered bitwise logic unit.
// Optional feature macro: LOGIC_GATE_XOR_EN (op 11 becomes XOR instead of reserved).
package logic_gate_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_NOT  = 2'b10,
    OP_RSVD = 2'b11
  } gate_op_e;

  // Lane width and lane count must both be at least one.
  function automatic bit lg_params_ok(input int width, input int sets);
    return (width >= 1) && (sets >= 1);
  endfunction

endpackage

// File: rtl/logic_gate_lane.sv
// One WIDTH-bit lane of the logic unit: purely combinational op decode.
// Optional feature macro: LOGIC_GATE_XOR_EN (op 11 computes A ^ B, never flags an error).
module logic_gate_lane
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             err
);

  // Select the lane result from the op code and flag unsupported codes.
  always_comb begin
    y   = '0;
    err = 1'b0;
    case (gate_op_e'(op))
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NOT:  y = ~a;
      OP_RSVD: begin
`ifdef LOGIC_GATE_XOR_EN
        y   = a ^ b;
`else
        y   = '0;
        err = 1'b1;
`endif
      end
      default: begin
        y   = '0;
        err = 1'b0;
      end
    endcase
    zero = (y == '0);
  end

endmodule

// File: rtl/logic_gate_unit.sv
// Registered bitwise logic unit: AND/OR/NOT over SETS packed WIDTH-bit lanes,
// one-cycle latency, no backpressure. Lane i occupies bits [i*WIDTH +: WIDTH].
// Optional feature macro: LOGIC_GATE_XOR_EN (op 11 = XOR; op_err never asserts).
module logic_gate_unit
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int SETS  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [1:0]            op,
  input  logic [SETS*WIDTH-1:0] in1_packed,
  input  logic [SETS*WIDTH-1:0] in2_packed,
  output logic [SETS*WIDTH-1:0] out_packed,
  output logic [SETS-1:0]       zero_flags,
  output logic                  out_valid,
  output logic                  op_err
);

  if (!lg_params_ok(WIDTH, SETS)) begin : g_param_err
    $error("logic_gate_unit: WIDTH (%0d) and SETS (%0d) must both be >= 1", WIDTH, SETS);
  end

  logic [SETS*WIDTH-1:0] lane_y;
  logic [SETS-1:0]       lane_zero;
  logic [SETS-1:0]       lane_err;

  for (genvar i = 0; i < SETS; i++) begin : g_lane
    logic_gate_lane #(
      .WIDTH (WIDTH)
    ) u_lane (
      .op   (op),
      .a    (in1_packed[i*WIDTH +: WIDTH]),
      .b    (in2_packed[i*WIDTH +: WIDTH]),
      .y    (lane_y[i*WIDTH +: WIDTH]),
      .zero (lane_zero[i]),
      .err  (lane_err[i])
    );
  end

  logic [SETS*WIDTH-1:0] out_d,   out_q;
  logic [SETS-1:0]       zero_d,  zero_q;
  logic                  valid_d, valid_q;
  logic                  err_d,   err_q;

  // Load new results on an accepted op; otherwise hold data and drop valid.
  // The hold path never looks at op, so an X op while idle cannot propagate.
  always_comb begin
    out_d   = out_q;
    zero_d  = zero_q;
    err_d   = err_q;
    valid_d = in_valid;
    if (in_valid) begin
      out_d  = lane_y;
      zero_d = lane_zero;
      err_d  = |lane_err;
    end
  end

  // Output registers, cleared immediately by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      zero_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      zero_q  <= zero_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign out_packed = out_q;
  assign zero_flags = zero_q;
  assign out_valid  = valid_q;
  assign op_err     = err_q;

endmodule

// File: tb/tb_logic_gate_unit.sv
// Scoreboard bench for logic_gate_unit (WIDTH=4, SETS=2).
module tb_logic_gate_unit;

  localparam int WIDTH = 4;
  localparam int SETS  = 2;
  localparam int N     = WIDTH * SETS;

  typedef struct packed {
    logic [N-1:0]    out;
    logic [SETS-1:0] zf;
    logic            err;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic [1:0]      op = 2'b00;
  logic [N-1:0]    in1_packed = '0;
  logic [N-1:0]    in2_packed = '0;
  logic [N-1:0]    out_packed;
  logic [SETS-1:0] zero_flags;
  logic            out_valid;
  logic            op_err;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  exp_t last_exp;

  logic_gate_unit #(.WIDTH(WIDTH), .SETS(SETS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .op         (op),
    .in1_packed (in1_packed),
    .in2_packed (in2_packed),
    .out_packed (out_packed),
    .zero_flags (zero_flags),
    .out_valid  (out_valid),
    .op_err     (op_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: evaluates every output bit from the boolean rule of the op.
  function automatic exp_t model(input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t e;
    e.out = '0;
    e.zf  = '0;
    e.err = 1'b0;
    for (int l = 0; l < SETS; l++) begin
      int ones = 0;
      for (int k = 0; k < WIDTH; k++) begin
        int  idx = l * WIDTH + k;
        bit  x   = a[idx];
        bit  y   = b[idx];
        bit  r;
        case (o)
          2'd0: r = x && y;
          2'd1: r = x || y;
          2'd2: r = !x;
          default: begin
`ifdef LOGIC_GATE_XOR_EN
            r = (x != y);
`else
            r = 1'b0;
            e.err = 1'b1;
`endif
          end
        endcase
        e.out[idx] = r;
        if (r) ones++;
      end
      e.zf[l] = (ones == 0);
    end
    return e;
  endfunction

  // Monitor: every presented result must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: out_valid=1 with empty scoreboard, out=0x%0h", out_packed);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_packed", 64'(out_packed), 64'(e.out));
        check("zero_flags", 64'(zero_flags), 64'(e.zf));
        check("op_err",     64'(op_err),     64'(e.err));
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b);
    in_valid   = 1'b1;
    op         = o;
    in1_packed = a;
    in2_packed = b;
    last_exp   = model(o, a, b);
    sb.push_back(last_exp);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    in_valid   = 1'b0;
    op         = 2'($urandom);
    in1_packed = N'($urandom);
    in2_packed = N'($urandom);
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out"},   64'(out_packed), 64'(0));
    check({tag, "_zf"},    64'(zero_flags), 64'(0));
    check({tag, "_valid"}, 64'(out_valid),  64'(0));
    check({tag, "_err"},   64'(op_err),     64'(0));
  endtask

  initial begin
    // Reset held with random, valid-looking inputs.
    for (int i = 0; i < 4; i++) begin
      in_valid   = 1'b1;
      op         = 2'($urandom);
      in1_packed = N'($urandom);
      in2_packed = N'($urandom);
      @(posedge clk);
      #1;
    end
    check_all_zero("reset");
    in_valid = 1'b0;
    rst_n    = 1'b1;
    for (int i = 0; i < 2; i++) begin
      idle_cycle();
      check("post_reset_valid", 64'(out_valid), 64'(0));
    end

    // Directed cases.
    issue(2'b00, 8'hC3, 8'hA5);
    issue(2'b01, 8'h0F, 8'h30);
    issue(2'b10, 8'hF0, 8'h00);
    issue(2'b10, 8'hFF, 8'h5A);
    issue(2'b00, 8'hF0, 8'h0F);
    issue(2'b00, 8'hF1, 8'h01);
    issue(2'b11, 8'h3C, 8'h0F);
    idle_cycle();

    // Back-to-back AND, OR, NOT, then hold.
    issue(2'b00, 8'h96, 8'h3C);
    issue(2'b01, 8'h12, 8'h40);
    issue(2'b10, 8'hA5, 8'hFF);
    idle_cycle();
    check("hold_valid", 64'(out_valid),  64'(0));
    check("hold_out",   64'(out_packed), 64'(last_exp.out));
    check("hold_zf",    64'(zero_flags), 64'(last_exp.zf));
    idle_cycle();
    check("hold2_out",  64'(out_packed), 64'(last_exp.out));

    // Randomized traffic with bubbles.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(3) != 0)
        issue(2'($urandom), N'($urandom), N'($urandom));
      else
        idle_cycle();
    end

    // Reset asserted mid-stream clears immediately.
    issue(2'b01, 8'h5A, 8'h81);
    issue(2'b10, 8'h00, 8'h00);
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    sb.delete();
    check_all_zero("midreset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_cycle();
    check("midreset_idle_valid", 64'(out_valid), 64'(0));
    issue(2'b00, 8'h7E, 8'hE7);
    check("midreset_first_valid", 64'(out_valid), 64'(1));
    idle_cycle();

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && sb.size() != 0; i++) idle_cycle();
    check("scoreboard_drained", 64'(sb.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
